usart_tx_8251: RTL and testbench
================================

Name: usart_tx_8251

Overview:
Transmit half of the 8251-compatible USART in the PC-8001 serial/CMT path. It sits directly downstream of the 8251 control-register block and consumes its mode byte and command byte. It also accepts CPU writes to the 8251 data port. Each byte passes through a holding register into a shift register and is serialised on O_TXD as an asynchronous frame, with 8251-style O_TXRDY and O_TXEMPTY status.

Parameters:
none. Bit timing comes entirely from I_TXC_EN and the mode byte.

Ports:
I_CLK  in  1  system clock
I_RST  in  1  reset, synchronous, active-high
I_MODE  in  8  mode byte from control register
  [1:0] baud factor: 01=x1, 10=x16, 11=x64, 00 treated as x1
  [3:2] char length: 00=5, 01=6, 10=7, 11=8 bits
  [4] PEN (parity enable)
  [5] EP (1=even parity)
  [7:6] stop bits: 01=1, 10=1.5, 11=2, 00 treated as 1
I_CMD  in  8  command byte from control register; [0]=TxEN, [3]=SBRK
I_DATA_EN  in  1  data port selected
I_WE  in  1  write strobe (level)
I_DATA  in  8  CPU write data
I_TXC_EN  in  1  one-cycle transmit-clock enable pulse (TxC)
O_TXD  out  1  serial output, idle high
O_TXRDY  out  1  holding register empty and TxEN set
O_TXEMPTY  out  1  holding register empty and shifter idle
O_DEBUG_STATE  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock, I_CLK. I_RST is synchronous and active-high. All state updates occur on the I_CLK rising edge.
- Reset values: O_TXD=1, holding register empty, FSM=IDLE, tick and bit counters=0, O_TXEMPTY=1, O_DEBUG_STATE=0.
  - O_TXRDY = hold_empty & I_CMD[0], combinational from registered hold_empty.
- Reset mid-frame aborts the frame immediately; O_TXD=1 on the next cycle.
- Write detect:
  - wr = I_DATA_EN & I_WE, registered.
  - A rising edge of wr loads I_DATA into the holding register and sets hold_full on the same edge. A held strobe performs exactly one write.
  - A write while hold_full overwrites the holding data; the previous byte is lost.
- Load: in IDLE with hold_full=1, I_CMD[0]=1 and I_TXC_EN=1:
  - copy the holding register to the shifter;
  - latch I_MODE into a frame-format register;
  - clear hold_full;
  - go to START.
  - A simultaneous CPU write on the load cycle lands in the now-empty holding register, with hold_full=1.
- Frame format is fixed at load. Mode changes mid-frame affect only the next character.
- Bit period F = 1, 16 or 64 I_TXC_EN pulses, from the latched mode. A tick counter counts I_TXC_EN pulses and wraps at F.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - START: O_TXD=0 for F ticks.
  - DATA: LSB first, for the latched length (5 to 8 bits); unused upper bits are ignored.
  - PARITY: entered only if PEN=1. Bit = XOR of the transmitted data bits if EP=1, inverted XOR if EP=0.
  - STOP: O_TXD=1 for 1, 1.5 or 2 bit periods. 1.5 equals 1.5F ticks; at x1 it is rounded to 2.
  - After STOP: if hold_full & TxEN, load the next character back-to-back with no idle gap; otherwise go to IDLE.
- TxEN cleared mid-frame: the current character completes and no new load occurs. O_TXRDY drops combinationally.
- SBRK=1 forces O_TXD=0 in every state. The FSM keeps running, and the character in progress is sent as zeros.
- O_TXEMPTY = ~hold_full & (state==IDLE), registered. It goes to 1 one cycle after entering IDLE with the holding register empty.
- O_TXD is registered and updates on the cycle after the tick that ends the previous bit.

Test Plan:
- Reset, then I_MODE=8'h4E and I_CMD=8'h01; write 8'h55 with I_DATA_EN and I_WE held for 10 cycles, and I_TXC_EN pulsing every 4 clocks.
  - Exactly one character is sent: O_TXD = 0,1,0,1,0,1,0,1,0,1, each bit lasting 16 ticks.
  - O_TXRDY drops after the write and returns at load.
  - O_TXEMPTY rises after the stop bit.
- I_MODE=8'h79 (x1, 7-bit, even parity, 1 stop); write 8'h41.
  - O_TXD = 0,1,0,0,0,0,0,1,0,1.
  - Repeat with EP=0 (I_MODE=8'h59): the parity bit becomes 1.
- I_MODE=8'h4E; write 8'hA0, then 8'h0F once O_TXRDY returns.
  - The second frame's start bit immediately follows the first frame's stop bit, with no idle tick.
  - O_TXEMPTY stays 0 throughout.
- I_CMD=8'h00; write 8'h33.
  - O_TXD stays 1 and O_TXRDY stays 0; O_TXEMPTY=0 because the holding register is full.
  - Setting I_CMD=8'h01 starts the frame on the next I_TXC_EN.
- During a frame, set I_CMD=8'h09.
  - O_TXD=0 continuously.
  - Clearing SBRK restores the line at the next bit; the FSM timing is unchanged.
- Assert I_RST during the DATA state.
  - The next cycle gives O_TXD=1, O_TXEMPTY=1, O_DEBUG_STATE=0, with the holding register empty.

Source files
------------

// File: rtl/usart_tx_8251.sv
// ============================================================================
// usart_tx_8251 : 8251-compatible async transmitter (holding reg + shifter)
// Rev 1.0
// ============================================================================
`default_nettype none

module usart_tx_8251 (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic [7:0] I_MODE,
    input  logic [7:0] I_CMD,
    input  logic       I_DATA_EN,
    input  logic       I_WE,
    input  logic [7:0] I_DATA,
    input  logic       I_TXC_EN,
    output logic       O_TXD,
    output logic       O_TXRDY,
    output logic       O_TXEMPTY,
    output logic [2:0] O_DEBUG_STATE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] r_state;
    logic [6:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       r_wr;
    logic [7:0] r_shift;
    logic [7:0] r_fmt;
    logic       r_par;
    logic       r_txd;
    logic       r_txempty;

    logic [2:0] w_state_nxt;
    logic [2:0] w_bit_nxt;
    logic       w_load;
    logic       w_txd;
    logic       w_wr;
    logic       w_wr_rise;
    logic [7:0] w_tpb;
    logic [7:0] w_stop_len;
    logic [7:0] w_bit_len;
    logic       w_bit_end;
    logic       w_last_data;
    logic       w_can_load;
    logic [7:0] w_mask;
    logic       w_new_par;

    assign w_wr      = I_DATA_EN & I_WE;
    assign w_wr_rise = w_wr & ~r_wr;

    // Timing derives from the format latched at load, never the live mode byte
    always_comb begin
        case (r_fmt[1:0])
            2'b10:   w_tpb = 8'd16;
            2'b11:   w_tpb = 8'd64;
            default: w_tpb = 8'd1;
        endcase
        case (r_fmt[7:6])
            2'b10:   w_stop_len = (r_fmt[1] == 1'b0) ? 8'd2 : (w_tpb + (w_tpb >> 1));
            2'b11:   w_stop_len = w_tpb << 1;
            default: w_stop_len = w_tpb;
        endcase
    end

    assign w_bit_len   = (r_state == S_STOP) ? w_stop_len : w_tpb;
    assign w_bit_end   = I_TXC_EN & (r_state != S_IDLE) & ({1'b0, r_tick} == (w_bit_len - 8'd1));
    assign w_last_data = (r_bit == (3'd4 + {1'b0, r_fmt[3:2]}));
    assign w_can_load  = r_hold_full & I_CMD[0];

    always_comb begin
        case (I_MODE[3:2])
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_new_par = (^(r_hold & w_mask)) ^ ~I_MODE[5];

    // State register
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_load && I_TXC_EN) begin
                    w_state_nxt = S_START;
                    w_load      = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (w_last_data) begin
                        w_state_nxt = r_fmt[4] ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_can_load) begin
                        w_state_nxt = S_START;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: line level for the upcoming cycle, registered below
    always_comb begin
        w_txd = 1'b1;
        case (w_state_nxt)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = r_shift[w_bit_nxt];
            S_PARITY: w_txd = r_par;
            default:  w_txd = 1'b1;
        endcase
        if (I_CMD[3]) begin
            w_txd = 1'b0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_tick      <= 7'd0;
            r_bit       <= 3'd0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_wr        <= 1'b0;
            r_shift     <= 8'h00;
            r_fmt       <= 8'h00;
            r_par       <= 1'b0;
            r_txd       <= 1'b1;
            r_txempty   <= 1'b1;
        end else begin
            r_wr      <= w_wr;
            r_bit     <= w_bit_nxt;
            r_txd     <= w_txd;
            r_txempty <= ~r_hold_full & (r_state == S_IDLE);

            if (w_load || w_bit_end || (r_state == S_IDLE)) begin
                r_tick <= 7'd0;
            end else if (I_TXC_EN) begin
                r_tick <= r_tick + 7'd1;
            end

            if (w_load) begin
                r_shift <= r_hold;
                r_fmt   <= I_MODE;
                r_par   <= w_new_par;
            end

            // A write on the load cycle refills the holding register just vacated
            if (w_wr_rise) begin
                r_hold      <= I_DATA;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign O_TXD         = r_txd;
    assign O_TXRDY       = ~r_hold_full & I_CMD[0];
    assign O_TXEMPTY     = r_txempty;
    assign O_DEBUG_STATE = r_state;

endmodule

`default_nettype wire

// File: tb/tb_usart_tx_8251.sv
// ============================================================================
// tb_usart_tx_8251 : directed self-checking bench for usart_tx_8251
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_usart_tx_8251;

    logic       clk;
    logic       I_RST;
    logic [7:0] I_MODE;
    logic [7:0] I_CMD;
    logic       I_DATA_EN;
    logic       I_WE;
    logic [7:0] I_DATA;
    logic       I_TXC_EN;
    logic       O_TXD;
    logic       O_TXRDY;
    logic       O_TXEMPTY;
    logic [2:0] O_DEBUG_STATE;

    int n_checks = 0;
    int n_errors = 0;
    int txc_cnt  = 0;
    int run_len  = 0;
    int last_run = 0;
    int low_total = 0;
    int empty_hits = 0;
    bit mon_on = 0;

    usart_tx_8251 u_dut (
        .I_CLK         (clk),
        .I_RST         (I_RST),
        .I_MODE        (I_MODE),
        .I_CMD         (I_CMD),
        .I_DATA_EN     (I_DATA_EN),
        .I_WE          (I_WE),
        .I_DATA        (I_DATA),
        .I_TXC_EN      (I_TXC_EN),
        .O_TXD         (O_TXD),
        .O_TXRDY       (O_TXRDY),
        .O_TXEMPTY     (O_TXEMPTY),
        .O_DEBUG_STATE (O_DEBUG_STATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TxC enable: one pulse every 4 clocks
    initial I_TXC_EN = 1'b0;
    always @(negedge clk) begin
        txc_cnt  = (txc_cnt + 1) % 4;
        I_TXC_EN = (txc_cnt == 0);
    end

    // Line monitors: low-run length, total low samples, TXEMPTY hits
    always @(negedge clk) begin
        if (O_TXD == 1'b0) begin
            run_len   = run_len + 1;
            low_total = low_total + 1;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (mon_on && O_TXEMPTY) empty_hits = empty_hits + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, input int hold);
        @(negedge clk);
        I_DATA    = d;
        I_DATA_EN = 1'b1;
        I_WE      = 1'b1;
        repeat (hold) @(negedge clk);
        I_DATA_EN = 1'b0;
        I_WE      = 1'b0;
    endtask

    task automatic wait_fall(output int cyc);
        cyc = 0;
        while (O_TXD === 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("start_fall", {31'b0, O_TXD}, 32'd0);
    endtask

    task automatic capture(input int nbits, input int cpb, output logic [31:0] bits, output int wcyc);
        bits = '0;
        wait_fall(wcyc);
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bits[i] = O_TXD;
            if (i < nbits - 1) repeat (cpb) @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bits;
        int          wcyc;
        int          cnt;
        int          low_snap;

        I_RST = 1'b1; I_MODE = 8'h4E; I_CMD = 8'h01;
        I_DATA_EN = 1'b0; I_WE = 1'b0; I_DATA = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_txd",     {31'b0, O_TXD},     32'd1);
        check("rst_txempty", {31'b0, O_TXEMPTY}, 32'd1);
        check("rst_state",   {29'b0, O_DEBUG_STATE}, 32'd0);
        check("rst_txrdy",   {31'b0, O_TXRDY},   32'd1);
        I_RST = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 0x55, x16 8N1, strobe held 10 cycles
        fork
            write_byte(8'h55, 10);
            begin
                @(negedge clk); @(negedge clk);
                check("t1_txrdy_low", {31'b0, O_TXRDY}, 32'd0);
            end
            capture(10, 64, bits, wcyc);
        join
        check("t1_frame",   bits, 32'b1010101010);
        check("t1_bitlen",  last_run, 32'd64);
        check("t1_txrdy_back", {31'b0, O_TXRDY}, 32'd1);
        check("t1_empty_in_stop", {31'b0, O_TXEMPTY}, 32'd0);
        low_snap = low_total;
        repeat (300) @(negedge clk);
        check("t1_one_char", low_total - low_snap, 32'd0);
        check("t1_empty_after", {31'b0, O_TXEMPTY}, 32'd1);

        // 2: x1, 7-bit, even then odd parity
        I_MODE = 8'h79;
        fork
            write_byte(8'h41, 1);
            capture(10, 4, bits, wcyc);
        join
        check("t2_even", bits, 32'b1010000010);
        repeat (20) @(negedge clk);
        I_MODE = 8'h59;
        fork
            write_byte(8'h41, 1);
            capture(10, 4, bits, wcyc);
        join
        check("t2_odd", bits, 32'b1110000010);
        repeat (20) @(negedge clk);

        // 3: back-to-back frames
        I_MODE = 8'h4E;
        empty_hits = 0;
        fork
            begin
                write_byte(8'hA0, 1);
                @(negedge clk); @(negedge clk);
                mon_on = 1;
                cnt = 0;
                while (!O_TXRDY && cnt < 100) begin
                    @(negedge clk);
                    cnt++;
                end
                write_byte(8'h0F, 1);
            end
            capture(20, 64, bits, wcyc);
        join
        mon_on = 0;
        check("t3_frames", bits, 32'h87B40);
        check("t3_empty_low", empty_hits, 32'd0);
        repeat (100) @(negedge clk);
        check("t3_empty_end", {31'b0, O_TXEMPTY}, 32'd1);

        // 4: TxEN off holds the character
        I_CMD = 8'h00;
        write_byte(8'h33, 1);
        low_snap = low_total;
        repeat (200) @(negedge clk);
        check("t4_line_idle", low_total - low_snap, 32'd0);
        check("t4_txrdy",     {31'b0, O_TXRDY},   32'd0);
        check("t4_txempty",   {31'b0, O_TXEMPTY}, 32'd0);
        I_CMD = 8'h01;
        capture(10, 64, bits, wcyc);
        check("t4_start_lat", {31'b0, (wcyc <= 4)}, 32'd1);
        check("t4_frame", bits, 32'b1001100110);
        repeat (100) @(negedge clk);

        // 5: break during data bits 1..2
        fork
            write_byte(8'hFF, 1);
            capture(10, 64, bits, wcyc);
            begin
                wait_fall(cnt);
                repeat (140) @(negedge clk);
                I_CMD = 8'h09;
                repeat (60) @(negedge clk);
                check("t5_brk_txd",   {31'b0, O_TXD}, 32'd0);
                check("t5_brk_state", {29'b0, O_DEBUG_STATE}, 32'd2);
                repeat (70) @(negedge clk);
                I_CMD = 8'h01;
            end
        join
        check("t5_frame", bits, 32'b1111110010);
        repeat (100) @(negedge clk);

        // 6: reset in the middle of DATA
        fork
            write_byte(8'h00, 1);
            wait_fall(cnt);
        join
        repeat (100) @(negedge clk);
        check("t6_in_data", {29'b0, O_DEBUG_STATE}, 32'd2);
        check("t6_txd_low", {31'b0, O_TXD}, 32'd0);
        write_byte(8'h12, 1);
        check("t6_hold_full", {31'b0, O_TXRDY}, 32'd0);
        I_RST = 1'b1;
        @(negedge clk);
        I_RST = 1'b0;
        check("t6_txd",     {31'b0, O_TXD},     32'd1);
        check("t6_txempty", {31'b0, O_TXEMPTY}, 32'd1);
        check("t6_state",   {29'b0, O_DEBUG_STATE}, 32'd0);
        check("t6_txrdy",   {31'b0, O_TXRDY},   32'd1);
        low_snap = low_total;
        repeat (300) @(negedge clk);
        check("t6_no_frame", low_total - low_snap, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
